product_accumulator: RTL and testbench

Sequential stage directly downstream of the 4x4 combinational multiplier. Takes the 8-bit product (c5,p6..p0), accepts one product per valid/ready beat, and accumulates a block of BLOCK_LEN products into a saturating sum. It presents the block sum and sample count on a registered valid/ready output port. This turns the stateless multiplier into a dot-product/MAC datapath.

---
 rtl/product_acc_pkg.sv | 27 ++
 rtl/product_accumulator.sv | 101 ++++++++++
 tb/tb_product_accumulator.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/product_acc_pkg.sv
// rtl/product_acc_pkg.sv - shared types, default sizes and saturating add for product_accumulator
package product_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    localparam int PROD_W_DEF    = 8;
    localparam int ACC_W_DEF     = 12;
    localparam int BLOCK_LEN_DEF = 16;

    // Returns {ovf, sum}; sum clamps to 2^acc_w-1 (acc_w < 32) and ovf flags the clamp.
    function automatic logic [32:0] sat_add(input logic [31:0] acc,
                                            input logic [31:0] prod,
                                            input int          acc_w);
        logic [32:0] sum;
        logic [31:0] lim;
        sum = {1'b0, acc} + {1'b0, prod};
        lim = 32'((33'd1 << acc_w) - 33'd1);
        if (sum > {1'b0, lim}) begin
            return {1'b1, lim};
        end
        return {1'b0, sum[31:0]};
    endfunction

endpackage

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - block-wise saturating accumulator of multiplier products
// with a registered valid/ready result port.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int  PROD_W    = PROD_W_DEF,
    parameter int  ACC_W     = ACC_W_DEF,
    parameter int  BLOCK_LEN = BLOCK_LEN_DEF,
    localparam int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              flush,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    acc_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [32:0]       add_res;
    logic              add_ovf;
    logic [ACC_W-1:0]  add_sum;
    logic              unused_add_hi;
    logic              accept;

    assign add_res       = sat_add(32'(acc_q), 32'(in_product), ACC_W);
    assign add_ovf       = add_res[32];
    assign add_sum       = add_res[ACC_W-1:0];
    // Clamped result never exceeds ACC_W bits, so the upper bits carry no information.
    assign unused_add_hi = ^add_res[31:ACC_W];

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_d = add_sum;
                        cnt_d = cnt_q + CNT_W'(1);
                        ovf_d = ovf_q | add_ovf;
                        if (flush || cnt_d == CNT_W'(BLOCK_LEN)) begin
                            state_d = HOLD;
                        end
                    end else if (flush && cnt_q != '0) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed table and sequence checks for product_accumulator
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_product;
    logic        flush;
    logic        clear;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_ovf;
    logic [11:0] out_sum;
    logic [4:0]  out_count;
    logic        in_ready8, out_valid8, out_ovf8;
    logic [7:0]  out_sum8;
    logic [4:0]  out_count8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .flush(flush), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    product_accumulator #(.ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .in_product(in_product), .flush(flush), .clear(clear),
        .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8),
        .out_count(out_count8), .out_ovf(out_ovf8)
    );

    typedef struct {
        logic        iv;
        logic [7:0]  prod;
        logic        fl;
        logic        cl;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [11:0] e_sum;
        logic [4:0]  e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_ir, input logic e_ov,
                           input logic [11:0] e_sum, input logic [4:0] e_cnt, input logic e_ovf);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(e_ir));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, ".out_sum"},   32'(out_sum),   32'(e_sum));
        chk({tag, ".out_count"}, 32'(out_count), 32'(e_cnt));
        chk({tag, ".out_ovf"},   32'(out_ovf),   32'(e_ovf));
    endtask

    initial begin
        // Each row: inputs applied this cycle, outputs expected before the edge.
        //            iv    prod   fl    cl    ordy  ir    ov    sum     cnt    ovf
        vecs[0]  = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0,  5'd0,  1'b0};
        vecs[1]  = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0,  5'd0,  1'b0};
        vecs[2]  = '{1'b1, 8'd2,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0,  5'd0,  1'b0};
        vecs[3]  = '{1'b1, 8'd6,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'd2,  5'd1,  1'b0};
        vecs[4]  = '{1'b1, 8'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'd8,  5'd2,  1'b0};
        vecs[5]  = '{1'b1, 8'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'd18, 5'd3,  1'b0};
        vecs[6]  = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd18, 5'd3,  1'b0};
        vecs[7]  = '{1'b1, 8'd7,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0,  5'd0,  1'b0};
        vecs[8]  = '{1'b1, 8'd9,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'd7,  5'd1,  1'b0};
        vecs[9]  = '{1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0,  5'd0,  1'b0};
        vecs[10] = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0,  5'd0,  1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_product = '0; flush = 1'b0;
        clear = 1'b0; out_ready = 1'b1;
        #1;
        chk_all("reset", 1'b1, 1'b0, 12'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle flush, early flush, flush in HOLD, clear dropping a product.
        for (int i = 0; i < 11; i++) begin
            in_valid = vecs[i].iv; in_product = vecs[i].prod; flush = vecs[i].fl;
            clear = vecs[i].cl; out_ready = vecs[i].ordy;
            chk_all($sformatf("v%0d", i), vecs[i].e_ir, vecs[i].e_ov,
                    vecs[i].e_sum, vecs[i].e_cnt, vecs[i].e_ovf);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; clear = 1'b0; out_ready = 1'b1;

        // Full block of 16 x 225.
        in_valid = 1'b1; in_product = 8'd225;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i < 15) begin
                chk($sformatf("full.cnt%0d", i + 1), 32'(out_count), 32'(i + 1));
                chk($sformatf("full.ov%0d", i + 1), 32'(out_valid), 32'd0);
            end
        end
        in_valid = 1'b0;
        chk_all("full.done", 1'b0, 1'b1, 12'd3600, 5'd16, 1'b0);
        step();
        chk_all("full.back", 1'b1, 1'b0, 12'd0, 5'd0, 1'b0);

        // Clear mid-block with a colliding product, then a block of ones under backpressure.
        in_valid = 1'b1; in_product = 8'd3;
        repeat (5) step();
        chk_all("clr.pre", 1'b1, 1'b0, 12'd15, 5'd5, 1'b0);
        in_product = 8'd9; clear = 1'b1;
        chk("clr.in_ready", 32'(in_ready), 32'd1);
        step();
        clear = 1'b0;
        chk_all("clr.post", 1'b1, 1'b0, 12'd0, 5'd0, 1'b0);
        in_product = 8'd1; out_ready = 1'b0;
        repeat (16) step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_all($sformatf("bp%0d", i), 1'b0, 1'b1, 12'd16, 5'd16, 1'b0);
            step();
        end
        out_ready = 1'b1;
        chk_all("bp.rel", 1'b0, 1'b1, 12'd16, 5'd16, 1'b0);
        step();
        chk_all("bp.after", 1'b1, 1'b0, 12'd0, 5'd0, 1'b0);

        // Saturation on the 8-bit accumulator instance.
        in_valid = 1'b1; in_product = 8'd200;
        step();
        in_product = 8'd100; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("sat.valid", 32'(out_valid8), 32'd1);
        chk("sat.sum",   32'(out_sum8),   32'd255);
        chk("sat.ovf",   32'(out_ovf8),   32'd1);
        chk("sat.count", 32'(out_count8), 32'd2);
        chk_all("sat.wide", 1'b0, 1'b1, 12'd300, 5'd2, 1'b0);
        step();
        chk("sat.clr_ovf", 32'(out_ovf8), 32'd0);

        // Asynchronous reset mid-block.
        in_valid = 1'b1; in_product = 8'd4;
        repeat (4) step();
        chk("rst.pre", 32'(out_sum), 32'd16);
        #2 rst_n = 1'b0;
        #1;
        chk_all("rst.async", 1'b1, 1'b0, 12'd0, 5'd0, 1'b0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("rst.idle%0d", i), 1'b1, 1'b0, 12'd0, 5'd0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
